// File: rtl/ook_tx_pkg.sv
// ook_tx_pkg: shared types, constants and PRBS-7 helper for the OOK transmit framer and its receiver checker.
package ook_tx_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_SYNC, ST_PAY, ST_GAP} ook_state_t;

    localparam logic [31:0] PRE_PATTERN   = 32'hAAAAAAAA;
    localparam logic [31:0] SYNC_WORD_DEF = 32'h5A0FF0A5;

    // x^7 + x^6 + 1: feedback from state bits 6 and 5
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;
    localparam int PRBS_MAX_W = 64;

    typedef struct packed {
        logic [6:0]            state;
        logic [PRBS_MAX_W-1:0] bits;
    } prbs_res_t;

    // First generated bit lands in bits[n-1]; n must not exceed PRBS_MAX_W
    function automatic prbs_res_t prbs7_step_n(input logic [6:0] s, input int n);
        prbs_res_t r;
        logic fb;
        r.state = s;
        r.bits  = '0;
        for (int i = 0; i < PRBS_MAX_W; i++) begin
            if (i < n) begin
                fb      = r.state[PRBS_TAP_A] ^ r.state[PRBS_TAP_B];
                r.state = {r.state[5:0], fb};
                r.bits  = {r.bits[PRBS_MAX_W-2:0], fb};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability debouncer and rising-edge pulse for a raw button.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          level_q, level_d, rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // any cycle that agrees with the accepted level restarts the count
        if (sync2_q != level_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/ook_frame_gen.sv
// ook_frame_gen: OOK transmit framer emitting preamble, sync word, PRBS-7 payload and idle gap per button press.
module ook_frame_gen
    import ook_tx_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                PRE_WORDS   = 4,
    parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(SYNC_WORD_DEF),
    parameter int                FRAME_WORDS = 1024,
    parameter int                GAP_WORDS   = 16,
    parameter logic [6:0]        PRBS_SEED   = 7'h7F,
    parameter int                DEB_CYCLES  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_enable,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              frame_active,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frame_cnt
);
    localparam int MAX_A     = PRE_WORDS > FRAME_WORDS ? PRE_WORDS : FRAME_WORDS;
    localparam int MAX_WORDS = MAX_A > GAP_WORDS ? MAX_A : GAP_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_PRE = CNT_W'(PRE_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_WORDS - 1);
    localparam logic [DATA_W-1:0] PRE_WORD = DATA_W'({(DATA_W + 31) / 32 {PRE_PATTERN}});

    logic              trig, btn_level, unused;
    ook_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              active_q, active_d, done_q, done_d, abort_q, abort_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    prbs_res_t         prbs_r;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (send_enable),
        .level  (btn_level),
        .rise   (trig)
    );

    assign unused = ^{btn_level, prbs_r.bits >> DATA_W};

    // Outputs are computed for the state being entered, so tx_data always matches state_q
    always_comb begin
        prbs_r      = prbs7_step_n(lfsr_q, DATA_W);
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        tx_data_d   = '0;
        active_d    = 1'b0;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if ((state_q == ST_PRE || state_q == ST_SYNC || state_q == ST_PAY) && !tx_ready) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig && tx_ready) begin
                        state_d   = ST_PRE;
                        cnt_d     = '0;
                        lfsr_d    = PRBS_SEED;
                        tx_data_d = PRE_WORD;
                        active_d  = 1'b1;
                    end
                end
                ST_PRE: begin
                    state_d   = cnt_q == LAST_PRE ? ST_SYNC : ST_PRE;
                    tx_data_d = cnt_q == LAST_PRE ? SYNC_WORD : PRE_WORD;
                    cnt_d     = cnt_q + 1'b1;
                    active_d  = 1'b1;
                end
                ST_SYNC: begin
                    state_d   = ST_PAY;
                    cnt_d     = '0;
                    tx_data_d = prbs_r.bits[DATA_W-1:0];
                    lfsr_d    = prbs_r.state;
                    active_d  = 1'b1;
                end
                ST_PAY: begin
                    if (cnt_q == LAST_PAY) begin
                        state_d     = ST_GAP;
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        tx_data_d = prbs_r.bits[DATA_W-1:0];
                        lfsr_d    = prbs_r.state;
                        active_d  = 1'b1;
                    end
                end
                ST_GAP: begin
                    state_d = cnt_q == LAST_GAP ? ST_IDLE : ST_GAP;
                    cnt_d   = cnt_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lfsr_q      <= PRBS_SEED;
            tx_data_q   <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            tx_data_q   <= tx_data_d;
            active_q    <= active_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign frame_active = active_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign frame_cnt    = frame_cnt_q;
endmodule

// File: tb/tb_ook_frame_gen.sv
// tb_ook_frame_gen: randomized and directed bench for ook_frame_gen against a frame-position reference model.
module tb_ook_frame_gen;
    localparam int PRE = 2, FRM = 4, GAP = 2, DEB = 4;
    localparam int ACT = PRE + 1 + FRM, TOT = ACT + GAP;

    logic        clk = 1'b0, rst = 1'b1, send_enable = 1'b0, tx_ready = 1'b1;
    logic [31:0] tx_data;
    logic        frame_active, frame_done, frame_abort;
    logic [15:0] frame_cnt;

    ook_frame_gen #(
        .DATA_W(32), .PRE_WORDS(PRE), .FRAME_WORDS(FRM), .GAP_WORDS(GAP), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .send_enable(send_enable), .tx_ready(tx_ready),
        .tx_data(tx_data), .frame_active(frame_active), .frame_done(frame_done),
        .frame_abort(frame_abort), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic        chk_en = 1'b0;
    logic [31:0] pay_words [FRM];

    logic [1:0]  m_hist;
    logic        m_level, m_trig;
    int          m_run, m_idx = -1;
    logic [15:0] m_cnt;
    logic [31:0] exp_data;
    logic        exp_active, exp_done, exp_abort;

    int          obs_active, obs_done, obs_abort;
    logic [31:0] obs_words [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < 0 || idx >= ACT) return 32'h0;
        if (idx < PRE) return 32'hAAAAAAAA;
        if (idx == PRE) return 32'h5A0FF0A5;
        return pay_words[idx-PRE-1];
    endfunction

    // Reference: button history, stability run length, and position within the frame
    always @(posedge clk) begin
        if (rst) begin
            m_hist = 2'b00; m_level = 1'b0; m_trig = 1'b0; m_run = 0; m_idx = -1; m_cnt = 16'd0;
            exp_done = 1'b0; exp_abort = 1'b0;
        end else begin
            exp_done = 1'b0; exp_abort = 1'b0;
            if (m_idx >= 0 && m_idx < ACT && !tx_ready) begin
                m_idx = -1; exp_abort = 1'b1;
            end else if (m_idx >= 0) begin
                m_idx++;
                if (m_idx == TOT) m_idx = -1;
                else if (m_idx == ACT) begin exp_done = 1'b1; m_cnt++; end
            end else if (m_trig && tx_ready) m_idx = 0;
            m_trig = 1'b0;
            if (m_hist[1] != m_level) begin
                m_run++;
                if (m_run == DEB) begin m_level = m_hist[1]; m_run = 0; m_trig = m_level; end
            end else m_run = 0;
            m_hist = {m_hist[0], send_enable};
        end
        exp_data   = word_at(m_idx);
        exp_active = m_idx >= 0 && m_idx < ACT;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_data", tx_data, exp_data);
            chk("frame_active", {31'b0, frame_active}, {31'b0, exp_active});
            chk("frame_done", {31'b0, frame_done}, {31'b0, exp_done});
            chk("frame_abort", {31'b0, frame_abort}, {31'b0, exp_abort});
            chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, m_cnt});
            if (frame_active) begin obs_words.push_back(tx_data); obs_active++; end
            if (frame_done) obs_done++;
            if (frame_abort) obs_abort++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        obs_words.delete(); obs_active = 0; obs_done = 0; obs_abort = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; send_enable = 1'b0; tx_ready = 1'b1;
        tick(10);
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic press(input int hi, input int after);
        send_enable = 1'b1; tick(hi);
        send_enable = 1'b0; tick(after);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pb [7 + FRM*32];
        int k;
        for (int i = 0; i < 7; i++) pb[i] = 1'b1;
        for (int i = 7; i < 7 + FRM*32; i++) pb[i] = pb[i-7] ^ pb[i-6];
        for (int w = 0; w < FRM; w++)
            for (int j = 0; j < 32; j++) pay_words[w][31-j] = pb[7 + 32*w + j];
        chk("model_pay0", pay_words[0], 32'h020C28F2);
        tick(1);
        chk_en = 1'b1;

        do_reset(); tick(30);
        chk("idle_cnt", {16'b0, frame_cnt}, 0);
        chk("idle_active", obs_active, 0);

        do_reset(); press(20, 30);
        chk("single_active", obs_active, 7);
        chk("single_done", obs_done, 1);
        chk("single_abort", obs_abort, 0);
        chk("single_cnt", {16'b0, frame_cnt}, 1);
        chk("single_len", obs_words.size(), 7);
        if (obs_words.size() >= 4) begin
            chk("single_pre0", obs_words[0], 32'hAAAAAAAA);
            chk("single_pre1", obs_words[1], 32'hAAAAAAAA);
            chk("single_sync", obs_words[2], 32'h5A0FF0A5);
            chk("single_pay0", obs_words[3], 32'h020C28F2);
        end

        do_reset();
        for (int i = 0; i < 20; i++) begin send_enable = ~send_enable; tick(2); end
        send_enable = 1'b0; tick(30);
        chk("bounce_active", obs_active, 0);
        chk("bounce_cnt", {16'b0, frame_cnt}, 0);

        do_reset(); press(20, 30); press(20, 30);
        chk("repeat_cnt", {16'b0, frame_cnt}, 2);
        chk("repeat_done", obs_done, 2);
        chk("repeat_len", obs_words.size(), 14);
        if (obs_words.size() == 14) begin
            chk("repeat_pay0_a", obs_words[3], 32'h020C28F2);
            chk("repeat_pay0_b", obs_words[10], 32'h020C28F2);
        end

        do_reset();
        send_enable = 1'b1; tick(4); send_enable = 1'b0; tick(4);
        send_enable = 1'b1; tick(20); send_enable = 1'b0; tick(30);
        chk("busy_cnt", {16'b0, frame_cnt}, 1);
        chk("busy_done", obs_done, 1);
        chk("busy_active", obs_active, 7);

        do_reset();
        send_enable = 1'b1;
        k = 0;
        while (m_idx != PRE + 2 && k < 100) begin tick(1); k++; end
        chk("abort_reach_pay1", {31'b0, k < 100}, 1);
        tx_ready = 1'b0;
        tick(1);
        @(negedge clk);
        chk("abort_tx_zero", tx_data, 32'h0);
        chk("abort_pulse", {31'b0, frame_abort}, 1);
        #1 send_enable = 1'b0; tick(10);
        tx_ready = 1'b1; tick(10);
        chk("abort_count", obs_abort, 1);
        chk("abort_no_done", obs_done, 0);
        chk("abort_cnt", {16'b0, frame_cnt}, 0);
        clear_stats();
        press(20, 30);
        chk("after_abort_cnt", {16'b0, frame_cnt}, 1);
        chk("after_abort_len", obs_words.size(), 7);
        if (obs_words.size() >= 4) chk("after_abort_pay0", obs_words[3], 32'h020C28F2);

        do_reset();
        repeat (300) begin
            send_enable = 1'($urandom_range(0, 1));
            tx_ready    = $urandom_range(0, 7) != 0;
            rst         = $urandom_range(0, 63) == 0;
            tick($urandom_range(1, 12));
        end
        rst = 1'b0; tx_ready = 1'b1; send_enable = 1'b0;
        tick(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ook_frame_gen.md
Name: ook_frame_gen

Overview:
- Transmit framer for the underwater OOK link. Sits directly upstream of the GTX transmitter and drives its parallel TX data word.
- On a debounced press of the SEND_ENABLE button, emits one frame: preamble, then sync word, then PRBS-7 payload, then an idle gap.
- Between frames it drives all-zero words (light off).
- PRBS is reseeded at every frame start, so every frame is bit-identical and the receiver can run BER checks against it.

Parameters:
- DATA_W, 32, GTX TX parallel data width; bit DATA_W-1 goes on the line first.
- PRE_WORDS, 4, number of preamble words, each 0xAAAAAAAA (pattern truncated or repeated to DATA_W).
- SYNC_WORD, 32'h5A0FF0A5, frame sync word, DATA_W bits.
- FRAME_WORDS, 1024, number of PRBS payload words per frame (≥1).
- GAP_WORDS, 16, zero words after the payload before a new frame may start (≥1).
- PRBS_SEED, 7'h7F, LFSR seed loaded at each frame start (must be non-zero).
- DEB_CYCLES, 1000000, number of cycles the button must be stable before its level is accepted (≥2).

Ports:
- clk  in  1  TX user clock (GTX TXUSRCLK2 domain).
- rst  in  1  synchronous, active-high reset.
- send_enable  in  1  raw button, asynchronous to clk.
- tx_ready  in  1  GTX TX reset done / link ready, synchronous to clk.
- tx_data  out  DATA_W  word to GTX TXDATA, registered.
- frame_active  out  1  high while a preamble, sync or payload word is on tx_data.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_abort  out  1  one-cycle pulse when a frame is aborted by tx_ready loss.
- frame_cnt  out  16  completed-frame count; wraps 0xFFFF→0.

Behaviour:
- Reset values:
  - tx_data=0, frame_active=0, frame_done=0, frame_abort=0, frame_cnt=0.
  - FSM=IDLE, LFSR=PRBS_SEED.
  - Synchronizer flops=0, debounced level=0, debounce counter=0.
- Button path:
  - Two-flop synchronizer, then a debouncer.
  - The debouncer accepts a new level only after the synced input has differed from the accepted level for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
  - Trigger = rising edge of the accepted level (a single-cycle pulse).
- FSM states: IDLE, PRE, SYNC, PAY, GAP. A word counter tracks position inside PRE, PAY and GAP.
- IDLE:
  - tx_data=0.
  - On trigger with tx_ready=1: load LFSR=PRBS_SEED and go to PRE. The first preamble word appears on tx_data in the next cycle (latency 1 from trigger).
  - A trigger with tx_ready=0 is dropped.
- PRE: PRE_WORDS cycles of preamble, then SYNC.
- SYNC: one cycle of SYNC_WORD, then PAY.
- PAY: FRAME_WORDS cycles of PRBS words, then GAP.
- GAP:
  - GAP_WORDS cycles of zeros, then IDLE.
  - frame_done and the frame_cnt increment both happen in the first GAP cycle.
- frame_active: 1 exactly in PRE, SYNC and PAY output cycles, i.e. PRE_WORDS+1+FRAME_WORDS cycles per frame.
- PRBS-7 (x^7+x^6+1), Fibonacci form:
  - Per bit: out = s[6]^s[5]; s <= {s[5:0], out}.
  - DATA_W bits are generated per clock by unrolling this combinationally. The first generated bit goes in bit DATA_W-1.
  - The LFSR advances only in PAY cycles.
- Triggers arriving in PRE, SYNC, PAY or GAP are ignored; they are not queued.
- tx_ready falls during PRE, SYNC or PAY:
  - Next cycle: tx_data=0, FSM=IDLE, frame_abort pulses.
  - frame_done does not pulse and frame_cnt is unchanged.
- tx_ready falling in GAP is not an abort; the gap simply continues.
- Reset asserted mid-frame: all state returns to reset values on the next clock edge; no done or abort pulse is emitted.

Decomposition:
- Shared package ook_tx_pkg holds:
  - FSM state enum.
  - Preamble pattern and default SYNC_WORD.
  - PRBS-7 tap constants.
  - Function prbs7_step_n(state, n), returning the next state and n output bits. The receiver checker reuses this function.
- One sub-module, btn_debounce (synchronizer + debounce counter + rising-edge pulse), parameterised by DEB_CYCLES. The top-level G_RST/LED logic reuses it.

Test Plan:
- Test-bench parameters for all scenarios: DEB_CYCLES=4, PRE_WORDS=2, FRAME_WORDS=4, GAP_WORDS=2, DATA_W=32.
- Reset then idle: rst=1 for 10 cycles then 0; send_enable=0 → tx_data=0, frame_active=0, frame_cnt=0 throughout.
- Single frame:
  - Stimulus: send_enable held high for 20 cycles with tx_ready=1.
  - Required output: 0xAAAAAAAA ×2, then 0x5A0FF0A5, then 4 PRBS words, the first being 0x020C28F2.
  - frame_active high for exactly 7 cycles; frame_done pulses once; frame_cnt=1; then 2 zero words.
- Bounce rejection: send_enable toggled every 2 cycles for 40 cycles, then held low → no frame, frame_cnt=0.
- Repeat identity: two separate presses → both payloads are identical, the first word 0x020C28F2 each time; frame_cnt=2.
- Press while busy: second press during PAY → ignored; exactly one frame emitted; frame_cnt=1.
- Abort: tx_ready dropped in the 2nd PAY cycle → next cycle tx_data=0 and frame_abort pulses once; frame_done never pulses; frame_cnt=0. A later press with tx_ready=1 sends a full frame whose first payload word is again 0x020C28F2.
